// File: rtl/viterbi_universal_dec_if.sv
// Start/length handshake and completion status for viterbi_universal_dec.
// The caller drives start and frame_len; the decoder answers with done and out_len.
interface viterbi_universal_dec_if;
    logic       start;
    logic [7:0] frame_len;
    logic       done;
    logic [7:0] out_len;

    modport master (output start, output frame_len, input done, input out_len);
    modport slave  (input start, input frame_len, output done, output out_len);
endinterface

// File: rtl/viterbi_universal_dec.sv
// Hard-decision Viterbi decoder for rate-1/2 convolutional codes of constraint length K.
// All NS states are updated in one ACS step per cycle, followed by one traceback step per cycle.
module viterbi_universal_dec #(
    parameter int             K  = 3,
    parameter logic [K-1:0]   G0 = 3'b111,
    parameter logic [K-1:0]   G1 = 3'b101
) (
    input  logic                    clk,
    input  logic                    rst_n,
    viterbi_universal_dec_if.slave  bus,
    input  logic [1:0]              syms_in [256],
    output logic [255:0]            bits_out
);
    localparam int        SW     = K - 1;
    localparam int        NS     = 1 << SW;
    localparam logic [9:0] PM_INF = 10'h3FF;

    typedef logic [SW-1:0] st_t;
    typedef logic [9:0]    pm_t;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACS    = 3'd1,
        S_TBINIT = 3'd2,
        S_TB     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q;
    pm_t             pm_q   [NS];
    logic [NS-1:0]   surv_q [256];
    logic [7:0]      t_q;
    logic [7:0]      len_q;
    st_t             tb_s_q;
    logic            done_q;
    logic [7:0]      out_len_q;
    logic [255:0]    bits_q;

    pm_t             pm_d   [NS];
    logic [NS-1:0]   dec_d;
    logic [1:0]      sym_s;
    st_t             nst_s;
    st_t             p0_s;
    st_t             p1_s;
    pm_t             c0_s;
    pm_t             c1_s;
    st_t             best_s;
    pm_t             best_m_s;
    logic            lt_s;

    function automatic logic [1:0] enc_sym(input st_t s, input logic u);
        logic [K-1:0] r;
        r = {s, u};
        enc_sym = {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        hamming2 = {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // The infinite initial metric must never wrap back to a small value.
    function automatic pm_t sat_add(input pm_t a, input logic [1:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {9'd0, b};
        sat_add = (s > {1'b0, PM_INF}) ? PM_INF : s[9:0];
    endfunction

    // Add-compare-select for every next state, plus the argmin used to seed traceback.
    always_comb begin
        sym_s    = syms_in[t_q];
        nst_s    = '0;
        p0_s     = '0;
        p1_s     = '0;
        c0_s     = '0;
        c1_s     = '0;
        dec_d    = '0;
        pm_d     = pm_q;
        best_s   = '0;
        best_m_s = pm_q[0];
        lt_s     = 1'b0;
        for (int n = 0; n < NS; n++) begin
            nst_s = st_t'(n);
            p0_s  = {1'b0, nst_s[SW-1:1]};
            p1_s  = {1'b1, nst_s[SW-1:1]};
            c0_s  = sat_add(pm_q[p0_s], hamming2(enc_sym(p0_s, nst_s[0]), sym_s));
            c1_s  = sat_add(pm_q[p1_s], hamming2(enc_sym(p1_s, nst_s[0]), sym_s));
            // Ties resolve to the b=0 predecessor.
            if (c1_s < c0_s) begin
                pm_d[n]  = c1_s;
                dec_d[n] = 1'b1;
            end else begin
                pm_d[n]  = c0_s;
                dec_d[n] = 1'b0;
            end
        end
        for (int i = 1; i < NS; i++) begin
            lt_s     = pm_q[i] < best_m_s;
            best_s   = lt_s ? st_t'(i) : best_s;
            best_m_s = lt_s ? pm_q[i] : best_m_s;
        end
    end

    // Control FSM, path metrics, survivor memory and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            t_q       <= 8'd0;
            len_q     <= 8'd0;
            tb_s_q    <= '0;
            done_q    <= 1'b0;
            out_len_q <= 8'd0;
            bits_q    <= '0;
            for (int i = 0; i < NS; i++) begin
                pm_q[i] <= '0;
            end
            for (int i = 0; i < 256; i++) begin
                surv_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        len_q     <= bus.frame_len;
                        t_q       <= 8'd0;
                        done_q    <= 1'b0;
                        out_len_q <= 8'd0;
                        bits_q    <= '0;
                        for (int i = 0; i < NS; i++) begin
                            pm_q[i] <= (i == 0) ? 10'd0 : PM_INF;
                        end
                        state_q   <= (bus.frame_len == 8'd0) ? S_DONE : S_ACS;
                    end else if (state_q == S_DONE) begin
                        done_q    <= 1'b1;
                        out_len_q <= len_q;
                    end else begin
                        done_q    <= 1'b0;
                    end
                end
                S_ACS: begin
                    pm_q          <= pm_d;
                    surv_q[t_q]   <= dec_d;
                    if (t_q == len_q - 8'd1) begin
                        state_q <= S_TBINIT;
                    end else begin
                        t_q     <= t_q + 8'd1;
                    end
                end
                S_TBINIT: begin
                    tb_s_q  <= best_s;
                    state_q <= S_TB;
                end
                S_TB: begin
                    bits_q[t_q] <= tb_s_q[0];
                    tb_s_q      <= {surv_q[t_q][tb_s_q], tb_s_q[SW-1:1]};
                    if (t_q == 8'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        t_q     <= t_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done    = done_q;
    assign bus.out_len = out_len_q;
    assign bits_out    = bits_q;
endmodule

// File: tb/tb_viterbi_universal_dec.sv
// Directed bench for viterbi_universal_dec using K=6 and K=7 instances fed from a reference encoder.
module tb_viterbi_universal_dec;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   syms [256];
    logic [255:0] bits6;
    logic [255:0] bits7;
    logic         info [256];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    viterbi_universal_dec_if bus6 ();
    viterbi_universal_dec_if bus7 ();

    viterbi_universal_dec #(.K(6), .G0(6'b111111), .G1(6'b101011)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6), .syms_in(syms), .bits_out(bits6));
    viterbi_universal_dec #(.K(7), .G0(7'b1111001), .G1(7'b1011011)) dut7 (
        .clk(clk), .rst_n(rst_n), .bus(bus7), .syms_in(syms), .bits_out(bits7));

    task automatic encode(input int k, input logic [7:0] g0, input logic [7:0] g1, input int len);
        int s;
        int r;
        logic [7:0] rv;
        s = 0;
        for (int i = 0; i < 256; i++) syms[i] = 2'b00;
        for (int i = 0; i < len; i++) begin
            r       = ((s << 1) | int'(info[i])) & ((1 << k) - 1);
            rv      = 8'(r);
            syms[i] = {^(rv & g0), ^(rv & g1)};
            s       = r & ((1 << (k - 1)) - 1);
        end
    endtask

    task automatic load_pattern(input int len);
        logic [7:0] pat;
        pat = 8'b10110100;
        for (int i = 0; i < 256; i++) info[i] = (i < len) ? pat[i % 8] : 1'b0;
    endtask

    function automatic int count_errs(input int which, input int len);
        int n;
        n = 0;
        for (int i = 0; i < len; i++)
            if (((which == 6) ? bits6[i] : bits7[i]) !== info[i]) n++;
        return n;
    endfunction

    function automatic int count_tail(input int which, input int len);
        int n;
        n = 0;
        for (int i = len; i < 256; i++)
            if (((which == 6) ? bits6[i] : bits7[i]) !== 1'b0) n++;
        return n;
    endfunction

    task automatic run_frame(input int which, input int len, output int cycles, output bit to);
        logic d;
        @(negedge clk);
        if (which == 6) begin
            bus6.frame_len = 8'(len);
            bus6.start     = 1'b1;
        end else begin
            bus7.frame_len = 8'(len);
            bus7.start     = 1'b1;
        end
        @(negedge clk);
        bus6.start = 1'b0;
        bus7.start = 1'b0;
        cycles = 1;
        d = (which == 6) ? bus6.done : bus7.done;
        while (!d && cycles < 600) begin
            @(negedge clk);
            cycles++;
            d = (which == 6) ? bus6.done : bus7.done;
        end
        to = !d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus6.start = 1'b0; bus6.frame_len = 8'd0;
        bus7.start = 1'b0; bus7.frame_len = 8'd0;
        #12;
        checks++;
        if (bus6.done !== 1'b0 || bus7.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b/%b want 0/0", bus6.done, bus7.done);
        end
        checks++;
        if (bus6.out_len !== 8'd0 || bus7.out_len !== 8'd0) begin
            errors++; $display("FAIL reset_out_len: got %0d/%0d want 0/0", bus6.out_len, bus7.out_len);
        end
        checks++;
        if (bits6 !== 256'd0 || bits7 !== 256'd0) begin
            errors++; $display("FAIL reset_bits: got nonzero bits_out want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_k6_clean();
        int c; bit to; int e;
        load_pattern(64);
        encode(6, 8'b00111111, 8'b00101011, 64);
        run_frame(6, 64, c, to);
        checks++;
        if (to || c < 130 || c > 132) begin
            errors++; $display("FAIL k6_latency: got %0d cycles (timeout=%0b) want 130..132", c, to);
        end
        checks++;
        if (bus6.out_len !== 8'd64) begin
            errors++; $display("FAIL k6_out_len: got %0d want 64", bus6.out_len);
        end
        e = count_errs(6, 64);
        checks++;
        if (e !== 0) begin
            errors++; $display("FAIL k6_clean_bits: got %0d bit errors want 0", e);
        end
        e = count_tail(6, 64);
        checks++;
        if (e !== 0) begin
            errors++; $display("FAIL k6_tail_zero: got %0d nonzero bits above frame want 0", e);
        end
    endtask

    task automatic test_k6_flip();
        int c; bit to; int e;
        load_pattern(64);
        encode(6, 8'b00111111, 8'b00101011, 64);
        syms[20][0] = ~syms[20][0];
        run_frame(6, 64, c, to);
        e = count_errs(6, 64);
        checks++;
        if (to || e !== 0) begin
            errors++; $display("FAIL k6_flip20: got %0d bit errors (timeout=%0b) want 0", e, to);
        end
    endtask

    task automatic test_k7();
        int c; bit to; int e;
        load_pattern(64);
        encode(7, 8'b01111001, 8'b01011011, 64);
        run_frame(7, 64, c, to);
        e = count_errs(7, 64);
        checks++;
        if (to || e !== 0 || bus7.out_len !== 8'd64) begin
            errors++; $display("FAIL k7_clean: got %0d errors len %0d (timeout=%0b) want 0 errors len 64", e, bus7.out_len, to);
        end
        syms[10][1] = ~syms[10][1];
        syms[40][0] = ~syms[40][0];
        run_frame(7, 64, c, to);
        e = count_errs(7, 64);
        checks++;
        if (to || e !== 0) begin
            errors++; $display("FAIL k7_flip10_40: got %0d bit errors (timeout=%0b) want 0", e, to);
        end
    endtask

    task automatic test_back_to_back();
        int c; bit to; int e;
        for (int i = 0; i < 256; i++) info[i] = (i < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        encode(7, 8'b01111001, 8'b01011011, 100);
        run_frame(7, 100, c, to);
        e = count_errs(7, 100);
        checks++;
        if (to || c < 202 || c > 204 || e !== 0 || bus7.out_len !== 8'd100) begin
            errors++; $display("FAIL back_to_back: got %0d errors len %0d after %0d cycles want 0 errors len 100 in 202..204",
                               e, bus7.out_len, c);
        end
    endtask

    task automatic test_zero_len();
        int c; bit to;
        run_frame(7, 0, c, to);
        checks++;
        if (to || c > 3) begin
            errors++; $display("FAIL zero_len_latency: got %0d cycles (timeout=%0b) want <=3", c, to);
        end
        checks++;
        if (bus7.out_len !== 8'd0 || bits7 !== 256'd0) begin
            errors++; $display("FAIL zero_len_outputs: got len %0d bits nonzero=%0b want len 0 bits 0",
                               bus7.out_len, bits7 != 256'd0);
        end
    endtask

    task automatic test_reset_mid();
        int c; bit to; int e;
        load_pattern(64);
        encode(7, 8'b01111001, 8'b01011011, 64);
        run_frame(7, 64, c, to);
        encode(6, 8'b00111111, 8'b00101011, 64);
        @(negedge clk);
        bus6.frame_len = 8'd64;
        bus6.start     = 1'b1;
        @(negedge clk);
        bus6.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus6.done !== 1'b0 || bus6.out_len !== 8'd0 || bits6 !== 256'd0) begin
            errors++; $display("FAIL midacs_reset_k6: got done %b len %0d want done 0 len 0 bits 0", bus6.done, bus6.out_len);
        end
        checks++;
        if (bus7.done !== 1'b0 || bus7.out_len !== 8'd0 || bits7 !== 256'd0) begin
            errors++; $display("FAIL async_reset_k7: got done %b len %0d want done 0 len 0 bits 0", bus7.done, bus7.out_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(6, 64, c, to);
        e = count_errs(6, 64);
        checks++;
        if (to || c < 130 || c > 132 || e !== 0 || bus6.out_len !== 8'd64) begin
            errors++; $display("FAIL post_reset_decode: got %0d errors len %0d after %0d cycles want 0 errors len 64",
                               e, bus6.out_len, c);
        end
    endtask

    task automatic test_noise();
        int c; bit to; int de; int fl;
        for (int lvl = 0; lvl <= 8; lvl++) begin
            de = 0;
            fl = 0;
            for (int f = 0; f < 4; f++) begin
                for (int i = 0; i < 256; i++) info[i] = (i < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
                encode(7, 8'b01111001, 8'b01011011, 64);
                for (int i = 0; i < 64; i++)
                    for (int b = 0; b < 2; b++)
                        if ($urandom_range(0, 999) < 25 * lvl) begin
                            syms[i][b] = ~syms[i][b];
                            fl++;
                        end
                run_frame(7, 64, c, to);
                checks++;
                if (to) begin
                    errors++; $display("FAIL noise_timeout: level %0d frame %0d got no done want done", lvl, f);
                end
                de += count_errs(7, 64);
            end
            $display("noise level %0d (x2.5%%): symbol bit flips=%0d of 512, decoded bit errors=%0d of 256", lvl, fl, de);
            if (lvl == 0) begin
                checks++;
                if (de !== 0) begin
                    errors++; $display("FAIL noise_0pct: got %0d decoded errors want 0", de);
                end
            end else if (lvl <= 2) begin
                checks++;
                if (fl == 0 || 2 * de >= fl) begin
                    errors++; $display("FAIL noise_ber_lvl%0d: got decoded errors %0d of 256 with %0d flips of 512 want lower BER",
                                       lvl, de, fl);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_k6_clean();
        test_k6_flip();
        test_k7();
        test_back_to_back();
        test_zero_len();
        test_reset_mid();
        test_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
